// File: rtl/control_sequencer_pkg.sv
// control_sequencer_pkg: shared state encoding, opcode constants, IR field
// positions and opcode-class helpers for the control sequencer.
// Optional feature macro: CU_MULDIV_EN (mul/div decode with HI/LO writeback).
package control_sequencer_pkg;

    typedef enum logic [3:0] {
        ST_RST  = 4'd0,
        ST_T0   = 4'd1,
        ST_T1   = 4'd2,
        ST_T2   = 4'd3,
        ST_T3   = 4'd4,
        ST_T4   = 4'd5,
        ST_T5   = 4'd6,
        ST_T6   = 4'd7,
        ST_HALT = 4'd8
    } state_e;

    // IR field bit positions
    localparam int unsigned OP_MSB = 31;
    localparam int unsigned OP_LSB = 27;
    localparam int unsigned RA_MSB = 26;
    localparam int unsigned RA_LSB = 23;
    localparam int unsigned RB_MSB = 22;
    localparam int unsigned RB_LSB = 19;
    localparam int unsigned RC_MSB = 18;
    localparam int unsigned RC_LSB = 15;

    localparam int unsigned OP_W  = 5;
    localparam int unsigned REG_W = 4;
    localparam int unsigned NREG  = 16;

    localparam logic [OP_W-1:0] OP_NONE = 5'b00000;
    localparam logic [OP_W-1:0] OP_ADD  = 5'b00011;
    localparam logic [OP_W-1:0] OP_SUB  = 5'b00100;
    localparam logic [OP_W-1:0] OP_SHR  = 5'b00101;
    localparam logic [OP_W-1:0] OP_SHL  = 5'b00110;
    localparam logic [OP_W-1:0] OP_ROR  = 5'b00111;
    localparam logic [OP_W-1:0] OP_ROL  = 5'b01000;
    localparam logic [OP_W-1:0] OP_AND  = 5'b01001;
    localparam logic [OP_W-1:0] OP_OR   = 5'b01010;
    localparam logic [OP_W-1:0] OP_MUL  = 5'b01110;
    localparam logic [OP_W-1:0] OP_DIV  = 5'b01111;
    localparam logic [OP_W-1:0] OP_NEG  = 5'b10000;
    localparam logic [OP_W-1:0] OP_NOT  = 5'b10001;
    localparam logic [OP_W-1:0] OP_HALT = 5'b11011;

`ifdef CU_MULDIV_EN
    localparam bit MULDIV_EN = 1'b1;
`else
    localparam bit MULDIV_EN = 1'b0;
`endif

    // mul/div only exist as instructions when the feature is built in
    function automatic logic is_muldiv(input logic [OP_W-1:0] op);
        return MULDIV_EN && ((op == OP_MUL) || (op == OP_DIV));
    endfunction

    // two-operand ops: Rb latched into Y in T3, Rc on the bus in T4
    function automatic logic is_binary(input logic [OP_W-1:0] op);
        logic b;
        case (op)
            OP_ADD, OP_SUB, OP_SHR, OP_SHL,
            OP_ROR, OP_ROL, OP_AND, OP_OR: b = 1'b1;
            default:                       b = is_muldiv(op);
        endcase
        return b;
    endfunction

    function automatic logic is_unary(input logic [OP_W-1:0] op);
        return (op == OP_NEG) || (op == OP_NOT);
    endfunction

endpackage

// File: rtl/control_sequencer_decode4to16.sv
// decode4to16: 4-bit register index to 16-bit one-hot select, all zero when
// en is low.
//   idx    : register index
//   en     : decode enable
//   onehot : one-hot output, bit n selects Rn
module decode4to16
    import control_sequencer_pkg::*;
(
    input  logic [REG_W-1:0] idx,
    input  logic             en,
    output logic [NREG-1:0]  onehot
);

    assign onehot = en ? (NREG'(1) << idx) : '0;

endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: hardwired multi-cycle control unit. Fetches through
// T0-T2 (with memory wait in T1), decodes the IR in T3 and drives the ALU
// datapath strobes through T4-T6; HALT holds until clr.
// Optional feature macro: CU_MULDIV_EN (mul/div, T6, HiIn/LoIn/Zhighout).
//   clk, clr            : clock, synchronous active-high reset
//   ir, mem_rdy         : instruction register, memory read data valid
//   PCout..MDRout, Rout : bus-source selects (at most one per cycle)
//   MARIn..read, HiIn/LoIn, Rin : load strobes and memory read request
//   opcode, halted      : ALU operation, halt indication
module control_sequencer
    import control_sequencer_pkg::*;
(
    input  logic             clk,
    input  logic             clr,
    input  logic [31:0]      ir,
    input  logic             mem_rdy,
    output logic             PCout,
    output logic             Zlowout,
    output logic             Zhighout,
    output logic             MDRout,
    output logic             MARIn,
    output logic             PCIn,
    output logic             MDRIn,
    output logic             IRIn,
    output logic             YIn,
    output logic             ZIn,
    output logic             IncPC,
    output logic             read,
    output logic             HiIn,
    output logic             LoIn,
    output logic [NREG-1:0]  Rout,
    output logic [NREG-1:0]  Rin,
    output logic [OP_W-1:0]  opcode,
    output logic             halted
);

    state_e state_q, state_d;
    logic   t1_wait_q, t1_wait_d;   // already spent at least one cycle in T1

    logic [OP_W-1:0]  ir_op;
    logic [REG_W-1:0] ra, rb, rc;
    logic             op_bin, op_un, op_md;
    logic             rout_en, rin_en;
    logic [REG_W-1:0] rout_idx, rin_idx;
    logic             unused_ir;

    assign ir_op     = ir[OP_MSB:OP_LSB];
    assign ra        = ir[RA_MSB:RA_LSB];
    assign rb        = ir[RB_MSB:RB_LSB];
    assign rc        = ir[RC_MSB:RC_LSB];
    assign op_bin    = is_binary(ir_op);
    assign op_un     = is_unary(ir_op);
    assign op_md     = is_muldiv(ir_op);
    assign unused_ir = ^ir[RC_LSB-1:0];

    // state register
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q   <= ST_RST;
            t1_wait_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            t1_wait_q <= t1_wait_d;
        end
    end

    // next state
    always_comb begin
        state_d   = state_q;
        t1_wait_d = 1'b0;
        case (state_q)
            ST_RST: state_d = ST_T0;
            ST_T0:  state_d = ST_T1;
            ST_T1: begin
                t1_wait_d = !mem_rdy;
                state_d   = mem_rdy ? ST_T2 : ST_T1;
            end
            ST_T2:  state_d = ST_T3;
            ST_T3: begin
                if (op_bin || op_un)         state_d = ST_T4;
                else if (ir_op == OP_HALT)   state_d = ST_HALT;
                else                         state_d = ST_T0;
            end
            ST_T4:  state_d = ST_T5;
            ST_T5:  state_d = op_md ? ST_T6 : ST_T0;
            ST_T6:  state_d = ST_T0;
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_RST;
        endcase
    end

    // outputs
    always_comb begin
        PCout    = 1'b0;
        Zlowout  = 1'b0;
        Zhighout = 1'b0;
        MDRout   = 1'b0;
        MARIn    = 1'b0;
        PCIn     = 1'b0;
        MDRIn    = 1'b0;
        IRIn     = 1'b0;
        YIn      = 1'b0;
        ZIn      = 1'b0;
        IncPC    = 1'b0;
        read     = 1'b0;
        HiIn     = 1'b0;
        LoIn     = 1'b0;
        opcode   = OP_NONE;
        halted   = 1'b0;
        rout_en  = 1'b0;
        rout_idx = rb;
        rin_en   = 1'b0;
        rin_idx  = ra;
        case (state_q)
            ST_T0: begin
                PCout  = 1'b1;
                MARIn  = 1'b1;
                IncPC  = 1'b1;
                ZIn    = 1'b1;
                opcode = OP_ADD;
            end
            ST_T1: begin
                // PC writeback only on entry; MDR loads on the data-valid cycle
                read    = 1'b1;
                Zlowout = !t1_wait_q;
                PCIn    = !t1_wait_q;
                MDRIn   = mem_rdy;
            end
            ST_T2: begin
                MDRout = 1'b1;
                IRIn   = 1'b1;
            end
            ST_T3: begin
                rout_en = op_bin;
                YIn     = op_bin;
            end
            ST_T4: begin
                rout_en  = 1'b1;
                rout_idx = op_bin ? rc : rb;
                ZIn      = 1'b1;
                opcode   = ir_op;
            end
            ST_T5: begin
                Zlowout = 1'b1;
`ifdef CU_MULDIV_EN
                LoIn    = op_md;
                rin_en  = !op_md && (ra != '0);
`else
                rin_en  = (ra != '0);
`endif
            end
            ST_T6: begin
`ifdef CU_MULDIV_EN
                Zhighout = 1'b1;
                HiIn     = 1'b1;
`endif
            end
            ST_HALT: halted = 1'b1;
            default: ;
        endcase
    end

    decode4to16 u_rout_dec (
        .idx    (rout_idx),
        .en     (rout_en),
        .onehot (Rout)
    );

    decode4to16 u_rin_dec (
        .idx    (rin_idx),
        .en     (rin_en),
        .onehot (Rin)
    );

endmodule
